ex_mdu: RTL
===========

EX_MDU -- requirements
Module: ex_mdu

Interface
REQ-001 Parameter: XLEN, 32, operand/result width in bits (>= 8, even).
REQ-002 Parameter: MUL_CYCLES, 2, fixed multiply latency in cycles from accept to done_o (1..4).
REQ-003 Port: clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst_n_i  input  1  reset; synchronous, active-low.
REQ-005 Port: valid_i  input  1  request valid; accepted when valid_i & ready_o & ~kill_i.
REQ-006 Port: op_i  input  3  operation: 0 MUL, 1 MULH, 2 MULHU, 3 DIV, 4 DIVU, 5 MOD, 6 MODU, 7 reserved.
REQ-007 Port: opd1_i  input  XLEN  rj operand (multiplicand/dividend).
REQ-008 Port: opd2_i  input  XLEN  rk operand (multiplier/divisor).
REQ-009 Port: kill_i  input  1  pipeline flush; aborts any in-flight operation.
REQ-010 Port: ready_o  output  1  unit can accept a request this cycle.
REQ-011 Port: busy_o  output  1  operation in flight, result not yet produced.
REQ-012 Port: done_o  output  1  one-cycle pulse; result_o valid this cycle.
REQ-013 Port: result_o  output  XLEN  result; held stable from done_o until next accept.

Function
REQ-014 FSM states SHALL be IDLE, MUL, DIV, DONE; ready_o = (state==IDLE | state==DONE); busy_o = (state==MUL | state==DIV).
REQ-015 Accept SHALL latch op and both operands; later changes on op_i/opd*_i SHALL NOT affect the operation.
REQ-016 Accept from IDLE or DONE SHALL transition to MUL (ops 0-2), DIV (ops 3-6), or DONE (op 7, result 0, done next cycle).
REQ-017 MUL: done_o SHALL assert exactly MUL_CYCLES cycles after the accept cycle; MUL = product[XLEN-1:0], MULH = signed product[2XLEN-1:XLEN], MULHU = unsigned product high half.
REQ-018 DIV: radix-2 restoring iteration, one quotient bit per cycle on magnitudes; done_o SHALL assert XLEN+1 cycles after accept.
REQ-019 Signed DIV quotient SHALL truncate toward zero; MOD remainder SHALL take the sign of the dividend.
REQ-020 Divisor zero: quotient all-ones, remainder = dividend, done_o exactly 1 cycle after accept (no iteration).
REQ-021 Signed overflow (dividend = -2^(XLEN-1), divisor = -1): quotient = dividend, remainder 0, done_o 1 cycle after accept.
REQ-022 DONE SHALL last one cycle then return to IDLE unless a new request is accepted in that cycle (back-to-back).
REQ-023 valid_i while busy_o=1 SHALL be ignored (no queueing); the requester holds valid_i.
REQ-024 kill_i SHALL force IDLE on the next edge, suppress any pending done_o, leave result_o unchanged; kill_i with valid_i same cycle: kill wins, no accept.
REQ-025 kill_i in the cycle done_o is high SHALL NOT retract that done_o.

Reset
REQ-026 rst_n_i low at a clock edge SHALL set state IDLE, result_o 0, done_o 0, busy_o 0, ready_o 1, clear iteration counter, including mid-operation.
REQ-027 Reset SHALL take priority over kill_i and valid_i.

Configuration
REQ-028 Macro EX_MDU_DIV_EN: defined -> divider present per REQ-018..021.
REQ-029 EX_MDU_DIV_EN undefined -> ops 3-6 treated as op 7 (result 0, done 1 cycle after accept), no divider logic instantiated.

Structure
REQ-030 Op encodings, state encodings and XLEN default SHALL be defines in common.vh, shared with ID decode.
REQ-031 Divider datapath SHALL be sub-module mdu_divider (start, operands, signed flag, quotient, remainder, done); multiplier pipeline inline.

Verification (XLEN=32, MUL_CYCLES=2)
REQ-032 MUL 0x0001_0000 x 0x0001_0000 -> done_o at T+2, result 0x0000_0000; MULHU same -> 0x0000_0001.
REQ-033 MULH 0xFFFF_FFFF x 0xFFFF_FFFF -> 0x0000_0000; MULHU same -> 0xFFFF_FFFE.
REQ-034 DIV -7 / 2 -> done at T+33, result 0xFFFF_FFFD; MOD -7 % 2 -> 0xFFFF_FFFF; DIVU 100/7 -> 14.
REQ-035 DIVU 5/0 -> 0xFFFF_FFFF at T+1; MOD 0x8000_0000 % 0xFFFF_FFFF -> 0 at T+1.
REQ-036 DIV accepted, kill_i at T+10 -> no done_o, ready_o at T+11, prior result_o unchanged; rst_n_i low at T+5 -> all outputs at reset values next cycle.
REQ-037 Build without EX_MDU_DIV_EN: DIV 8/2 -> result 0 at T+1; MUL 3x4 -> 12 at T+2.

Source files
------------

// File: rtl/ex_mdu_pkg.sv
// Shared MDU definitions: operation encodings, FSM states and decode helpers.
package ex_mdu_pkg;

    localparam int unsigned XlenDefault = 32;

    typedef enum logic [2:0] {
        OpMul   = 3'd0,
        OpMulh  = 3'd1,
        OpMulhu = 3'd2,
        OpDiv   = 3'd3,
        OpDivu  = 3'd4,
        OpMod   = 3'd5,
        OpModu  = 3'd6,
        OpRsvd  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMul  = 2'd1,
        StDiv  = 2'd2,
        StDone = 2'd3
    } state_e;

    function automatic logic op_is_mul(op_e op);
        return (op == OpMul) || (op == OpMulh) || (op == OpMulhu);
    endfunction

    function automatic logic op_is_div(op_e op);
        return (op == OpDiv) || (op == OpDivu) || (op == OpMod) || (op == OpModu);
    endfunction

    function automatic logic op_is_signed_div(op_e op);
        return (op == OpDiv) || (op == OpMod);
    endfunction

    function automatic logic op_is_rem(op_e op);
        return (op == OpMod) || (op == OpModu);
    endfunction

endpackage

// File: rtl/mdu_divider.sv
// Radix-2 restoring divider on operand magnitudes, one quotient bit per cycle.
// done_o flags the final iteration; quotient_o/remainder_o are valid in that cycle.
module mdu_divider #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic            signed_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] quotient_o,
    output logic [XLEN-1:0] remainder_o,
    output logic            done_o
);
    localparam int unsigned CntW = $clog2(XLEN + 1);

    logic            r_busy;
    logic [CntW-1:0] r_cnt;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_dvs;
    logic            r_neg_q;
    logic            r_neg_r;

    logic            w_neg_a;
    logic            w_neg_b;
    logic [XLEN:0]   w_rem_sh;
    logic [XLEN:0]   w_diff;
    logic            w_qbit;
    logic [XLEN-1:0] w_rem_nxt;
    logic [XLEN-1:0] w_quo_nxt;

    assign w_neg_a = signed_i & dividend_i[XLEN-1];
    assign w_neg_b = signed_i & divisor_i[XLEN-1];

    // Quotient register doubles as the dividend shift register.
    assign w_rem_sh  = {r_rem, r_quo[XLEN-1]};
    assign w_diff    = w_rem_sh - {1'b0, r_dvs};
    assign w_qbit    = ~w_diff[XLEN];
    assign w_rem_nxt = w_qbit ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
    assign w_quo_nxt = {r_quo[XLEN-2:0], w_qbit};

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_dvs   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (abort_i) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (start_i) begin
            r_busy  <= 1'b1;
            r_cnt   <= CntW'(XLEN);
            r_quo   <= w_neg_a ? -dividend_i : dividend_i;
            r_rem   <= '0;
            r_dvs   <= w_neg_b ? -divisor_i : divisor_i;
            r_neg_q <= w_neg_a ^ w_neg_b;
            r_neg_r <= w_neg_a;
        end else if (r_busy) begin
            r_quo <= w_quo_nxt;
            r_rem <= w_rem_nxt;
            r_cnt <= r_cnt - CntW'(1);
            if (r_cnt == CntW'(1)) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign done_o      = r_busy & (r_cnt == CntW'(1));
    assign quotient_o  = r_neg_q ? -w_quo_nxt : w_quo_nxt;
    assign remainder_o = r_neg_r ? -w_rem_nxt : w_rem_nxt;

endmodule

// File: rtl/ex_mdu.sv
// Multiply/divide unit: fixed-latency inline multiplier plus iterative divider.
// Divider present only when EX_MDU_DIV_EN is defined; otherwise ops 3-6 act as reserved.
module ex_mdu
    import ex_mdu_pkg::*;
#(
    parameter int unsigned XLEN       = XlenDefault,
    parameter int unsigned MUL_CYCLES = 2
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            valid_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] opd1_i,
    input  logic [XLEN-1:0] opd2_i,
    input  logic            kill_i,
    output logic            ready_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);
    localparam int unsigned CntW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CntW-1:0] MulLoad = CntW'((MUL_CYCLES > 1) ? MUL_CYCLES - 2 : 0);

    state_e          r_state;
    op_e             r_op;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [CntW-1:0] r_cnt;
    logic [XLEN-1:0] r_result;
    logic            r_done;

    op_e             w_op;
    logic            w_accept;

    assign w_op     = op_e'(op_i);
    assign w_accept = valid_i & ready_o & ~kill_i;

    // One shared 2*XLEN multiply; MULH sign-extends both operands, low half is sign-agnostic.
    function automatic logic [XLEN-1:0] mul_result(op_e op, logic [XLEN-1:0] a,
                                                   logic [XLEN-1:0] b);
        logic [2*XLEN-1:0] ea;
        logic [2*XLEN-1:0] eb;
        logic [2*XLEN-1:0] p;
        ea = {{XLEN{(op == OpMulh) & a[XLEN-1]}}, a};
        eb = {{XLEN{(op == OpMulh) & b[XLEN-1]}}, b};
        p  = ea * eb;
        return (op == OpMul) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    endfunction

`ifdef EX_MDU_DIV_EN
    logic            w_div_signed;
    logic            w_div_zero;
    logic            w_div_ovf;
    logic            w_div_start;
    logic            w_div_done;
    logic [XLEN-1:0] w_quo;
    logic [XLEN-1:0] w_rem;

    assign w_div_signed = op_is_signed_div(w_op);
    assign w_div_zero   = (opd2_i == '0);
    assign w_div_ovf    = w_div_signed & (opd1_i == {1'b1, {(XLEN-1){1'b0}}}) & (opd2_i == '1);
    assign w_div_start  = w_accept & op_is_div(w_op) & ~w_div_zero & ~w_div_ovf;

    mdu_divider #(
        .XLEN(XLEN)
    ) u_div (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .start_i    (w_div_start),
        .abort_i    (kill_i),
        .signed_i   (w_div_signed),
        .dividend_i (opd1_i),
        .divisor_i  (opd2_i),
        .quotient_o (w_quo),
        .remainder_o(w_rem),
        .done_o     (w_div_done)
    );
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state  <= StIdle;
            r_op     <= OpMul;
            r_a      <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (kill_i) begin
                r_state <= StIdle;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    StIdle, StDone: begin
                        if (w_accept) begin
                            r_op <= w_op;
                            r_a  <= opd1_i;
                            r_b  <= opd2_i;
                            if (op_is_mul(w_op)) begin
                                if (MUL_CYCLES == 1) begin
                                    r_result <= mul_result(w_op, opd1_i, opd2_i);
                                    r_done   <= 1'b1;
                                    r_state  <= StDone;
                                end else begin
                                    r_cnt   <= MulLoad;
                                    r_state <= StMul;
                                end
                            end
`ifdef EX_MDU_DIV_EN
                            else if (op_is_div(w_op)) begin
                                // Degenerate divides resolve without iterating.
                                if (w_div_zero) begin
                                    r_result <= op_is_rem(w_op) ? opd1_i : '1;
                                    r_done   <= 1'b1;
                                    r_state  <= StDone;
                                end else if (w_div_ovf) begin
                                    r_result <= op_is_rem(w_op) ? '0 : opd1_i;
                                    r_done   <= 1'b1;
                                    r_state  <= StDone;
                                end else begin
                                    r_state <= StDiv;
                                end
                            end
`endif
                            else begin
                                r_result <= '0;
                                r_done   <= 1'b1;
                                r_state  <= StDone;
                            end
                        end else begin
                            r_state <= StIdle;
                        end
                    end
                    StMul: begin
                        if (r_cnt == '0) begin
                            r_result <= mul_result(r_op, r_a, r_b);
                            r_done   <= 1'b1;
                            r_state  <= StDone;
                        end else begin
                            r_cnt <= r_cnt - CntW'(1);
                        end
                    end
                    StDiv: begin
`ifdef EX_MDU_DIV_EN
                        if (w_div_done) begin
                            r_result <= op_is_rem(r_op) ? w_rem : w_quo;
                            r_done   <= 1'b1;
                            r_state  <= StDone;
                        end
`else
                        r_state <= StIdle;
`endif
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

    assign ready_o  = (r_state == StIdle) | (r_state == StDone);
    assign busy_o   = (r_state == StMul) | (r_state == StDiv);
    assign done_o   = r_done;
    assign result_o = r_result;

endmodule
